fetch_prefetch_unit: RTL and testbench

Parametrised instruction fetch unit with a decoupling prefetch buffer. It issues sequential word fetches to instruction memory, one outstanding request at a time, with back-to-back issue on zero-wait memory. Fetched words are queued with their PCs in a FIFO_DEPTH-entry buffer and handed to decode over a valid/ready handshake. Branch redirects flush the buffer and discard any in-flight response. It sits between instruction memory and the decode stage.

---
 rtl/fetch_prefetch_unit_if.sv | 32 +++
 rtl/fetch_prefetch_unit.sv | 161 ++++++++++++++++
 tb/tb_fetch_prefetch_unit.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_prefetch_unit_if.sv
// ---------------------------------------------------------------------------
// fetch_prefetch_unit_if
// Bundles the two handshakes of the fetch unit: the instruction-memory
// request bus and the valid/ready hand-off to decode.
//   mem_addr / mem_re      : request address / request valid (fetch -> memory)
//   mem_rdata / mem_ready  : read data / request completion  (memory -> fetch)
//   instr_valid/instr/instr_pc : head of prefetch buffer   (fetch -> decode)
//   instr_ready            : decode accepts the head          (decode -> fetch)
// Modports: master = fetch unit side, slave = memory/decode environment side.
// ---------------------------------------------------------------------------
interface fetch_prefetch_unit_if #(
    parameter int ADDR_WIDTH = 20
);
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_re;
    logic [31:0]           mem_rdata;
    logic                  mem_ready;
    logic                  instr_valid;
    logic                  instr_ready;
    logic [31:0]           instr;
    logic [31:0]           instr_pc;

    modport master (
        output mem_addr, mem_re, instr_valid, instr, instr_pc,
        input  mem_rdata, mem_ready, instr_ready
    );

    modport slave (
        input  mem_addr, mem_re, instr_valid, instr, instr_pc,
        output mem_rdata, mem_ready, instr_ready
    );
endinterface

// File: rtl/fetch_prefetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_prefetch_unit
// Sequential instruction fetcher with a FIFO_DEPTH-entry prefetch buffer.
// One memory request outstanding at a time; on a zero-wait memory a new
// request is issued in the same cycle the previous one completes, giving a
// sustained rate of one instruction per cycle. A redirect flushes the buffer
// and discards any response still in flight.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   fetch_en          : allows new memory requests to be issued
//   redirect_valid/pc : restart fetch at redirect_pc (bits [1:0] forced 0)
//   fill_level        : buffer occupancy 0..FIFO_DEPTH
//   bus (master)      : memory request bus and decode handshake
// ---------------------------------------------------------------------------
module fetch_prefetch_unit #(
    parameter int          ADDR_WIDTH = 20,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          fetch_en,
    input  logic                          redirect_valid,
    input  logic [31:0]                   redirect_pc,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level,
    fetch_prefetch_unit_if.master         bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

    state_t                state_q;
    logic                  mem_re_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [31:0]           fetch_pc_q;
    logic [31:0]           req_pc_q;

    logic [31:0]           pc_q   [FIFO_DEPTH];
    logic [31:0]           word_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      count_d;

    logic                  push;
    logic                  pop;
    logic [31:0]           redirect_target;

    assign redirect_target = {redirect_pc[31:2], 2'b00};

    // A redirect cycle neither pushes nor pops: the buffer is being cleared.
    assign push = (state_q == REQ) && bus.mem_ready && !redirect_valid;
    assign pop  = (count_q != '0) && bus.instr_ready && !redirect_valid;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Request sequencer. In REQ the reissue guard uses count_d so the word
    // being pushed this cycle is accounted for; the new request then becomes
    // the single in-flight word, which can never overflow the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            mem_re_q   <= 1'b0;
            mem_addr_q <= '0;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (redirect_valid) begin
                        fetch_pc_q <= redirect_target;
                    end else if (fetch_en && (count_q < DEPTH_C)) begin
                        mem_re_q   <= 1'b1;
                        mem_addr_q <= fetch_pc_q[ADDR_WIDTH-1:0];
                        req_pc_q   <= fetch_pc_q;
                        fetch_pc_q <= fetch_pc_q + 32'd4;
                        state_q    <= REQ;
                    end
                end
                REQ: begin
                    if (bus.mem_ready) begin
                        if (redirect_valid) begin
                            fetch_pc_q <= redirect_target;
                            mem_re_q   <= 1'b0;
                            state_q    <= IDLE;
                        end else if (fetch_en && (count_d < DEPTH_C)) begin
                            mem_addr_q <= fetch_pc_q[ADDR_WIDTH-1:0];
                            req_pc_q   <= fetch_pc_q;
                            fetch_pc_q <= fetch_pc_q + 32'd4;
                        end else begin
                            mem_re_q <= 1'b0;
                            state_q  <= IDLE;
                        end
                    end else if (redirect_valid) begin
                        // Request cannot be withdrawn; wait it out in DRAIN.
                        fetch_pc_q <= redirect_target;
                        state_q    <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (redirect_valid) begin
                        fetch_pc_q <= redirect_target;
                    end
                    if (bus.mem_ready) begin
                        mem_re_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: begin
                    mem_re_q <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    // Prefetch buffer: circular FIFO of {pc, word}; pointers wrap naturally
    // because FIFO_DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                pc_q[i]   <= '0;
                word_q[i] <= '0;
            end
        end else if (redirect_valid) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                pc_q[wr_ptr_q]   <= req_pc_q;
                word_q[wr_ptr_q] <= bus.mem_rdata;
                wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

    assign bus.mem_re      = mem_re_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.instr_valid = (count_q != '0);
    assign bus.instr       = word_q[rd_ptr_q];
    assign bus.instr_pc    = pc_q[rd_ptr_q];
    assign fill_level      = count_q;

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_prefetch_unit
// Directed bench: a table of per-cycle {inputs, expected outputs} rows for
// streaming and buffer-full behaviour, plus hand-written sequences for
// redirect-with-wait-states, same-cycle redirect/response/pop, async reset
// mid-request and fetch_en drop. Memory returns mk(addr) for every address.
// ---------------------------------------------------------------------------
module tb_fetch_prefetch_unit;
    localparam int AW = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_en = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [2:0]  fill_level;

    always #5 clk = ~clk;

    fetch_prefetch_unit_if #(.ADDR_WIDTH(AW)) bus ();

    fetch_prefetch_unit #(
        .ADDR_WIDTH(AW),
        .FIFO_DEPTH(4),
        .RESET_PC  (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fetch_en      (fetch_en),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .fill_level    (fill_level),
        .bus           (bus)
    );

    // ---------------- memory model ----------------
    function automatic logic [31:0] mk(input logic [31:0] a);
        return 32'hABC0_0000 | {12'h000, a[19:0]};
    endfunction

    int   wait_states = 0;
    int   wcnt = 0;
    bit   manual = 1'b0;
    logic man_ready = 1'b0;
    logic model_ready = 1'b0;

    assign bus.mem_rdata = mk({12'h000, bus.mem_addr});
    assign bus.mem_ready = manual ? man_ready : model_ready;

    always @(negedge clk) begin
        if (bus.mem_re) begin
            if (wcnt >= wait_states) begin
                model_ready = 1'b1;
                wcnt = 0;
            end else begin
                model_ready = 1'b0;
                wcnt = wcnt + 1;
            end
        end else begin
            model_ready = 1'b0;
            wcnt = 0;
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input bit re, input logic [31:0] addr,
                           input bit valid, input logic [31:0] pc, input int fill);
        chk({tag, ".mem_re"}, 32'(bus.mem_re), 32'(re));
        chk({tag, ".mem_addr"}, 32'(bus.mem_addr), addr);
        chk({tag, ".instr_valid"}, 32'(bus.instr_valid), 32'(valid));
        chk({tag, ".fill_level"}, 32'(fill_level), 32'(fill));
        if (valid) begin
            chk({tag, ".instr_pc"}, bus.instr_pc, pc);
            chk({tag, ".instr"}, bus.instr, mk(pc));
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit          fen;
        bit          rdy;
        bit          re;
        logic [31:0] addr;
        bit          valid;
        logic [31:0] pc;
        int          fill;
    } vec_t;

    vec_t vecs[$];

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            fetch_en        = vecs[i].fen;
            bus.instr_ready = vecs[i].rdy;
            step();
            $display("row %0d: fen=%0b rdy=%0b -> re=%0b addr=%05h valid=%0b pc=%08h fill=%0d",
                     i, vecs[i].fen, vecs[i].rdy, bus.mem_re, bus.mem_addr,
                     bus.instr_valid, bus.instr_pc, fill_level);
            chk_out($sformatf("row%0d", i), vecs[i].re, vecs[i].addr,
                    vecs[i].valid, vecs[i].pc, vecs[i].fill);
        end
    endtask

    initial begin
        // Rows 0-4: zero-wait streaming from reset, instr_ready=1.
        //           fen rdy re  addr      valid pc     fill
        vecs.push_back('{1, 1, 1, 32'h00, 0, 32'h00, 0});
        vecs.push_back('{1, 1, 1, 32'h04, 1, 32'h00, 1});
        vecs.push_back('{1, 1, 1, 32'h08, 1, 32'h04, 1});
        vecs.push_back('{1, 1, 1, 32'h0C, 1, 32'h08, 1});
        vecs.push_back('{1, 1, 1, 32'h10, 1, 32'h0C, 1});
        // Rows 5-18: fill to 4 with instr_ready=0, single pop, refill, drain.
        vecs.push_back('{1, 0, 1, 32'h00, 0, 32'h00, 0});
        vecs.push_back('{1, 0, 1, 32'h04, 1, 32'h00, 1});
        vecs.push_back('{1, 0, 1, 32'h08, 1, 32'h00, 2});
        vecs.push_back('{1, 0, 1, 32'h0C, 1, 32'h00, 3});
        vecs.push_back('{1, 0, 0, 32'h0C, 1, 32'h00, 4});
        vecs.push_back('{1, 0, 0, 32'h0C, 1, 32'h00, 4});
        vecs.push_back('{1, 1, 0, 32'h0C, 1, 32'h04, 3});
        vecs.push_back('{1, 0, 1, 32'h10, 1, 32'h04, 3});
        vecs.push_back('{1, 0, 0, 32'h10, 1, 32'h04, 4});
        vecs.push_back('{1, 1, 0, 32'h10, 1, 32'h08, 3});
        vecs.push_back('{1, 1, 1, 32'h14, 1, 32'h0C, 2});
        vecs.push_back('{1, 1, 1, 32'h18, 1, 32'h10, 2});
        vecs.push_back('{1, 1, 1, 32'h1C, 1, 32'h14, 2});
        vecs.push_back('{1, 1, 1, 32'h20, 1, 32'h18, 2});

        bus.instr_ready = 1'b0;

        // Reset state.
        rst_n = 1'b0;
        step();
        chk_out("reset", 0, 32'h0, 0, 32'h0, 0);
        chk("reset.instr", bus.instr, 32'h0);
        chk("reset.instr_pc", bus.instr_pc, 32'h0);
        rst_n = 1'b1;

        // Streaming, zero-wait.
        run_rows(0, 4);

        // Async reset in the middle of an outstanding request.
        $display("async reset mid-REQ");
        rst_n = 1'b0;
        #1;
        chk_out("async_rst", 0, 32'h0, 0, 32'h0, 0);
        step();
        step();
        rst_n = 1'b1;

        // Full buffer / single pop / resumes at next sequential PC.
        run_rows(5, 18);

        // Redirect to 0x102 while request at 0x8 waits on 3 wait states.
        $display("redirect during wait-state request");
        wait_states = 3;
        fetch_en = 1'b1;
        bus.instr_ready = 1'b1;
        do_reset();
        begin
            bit found = 1'b0;
            for (int c = 0; c < 40 && !found; c++) begin
                step();
                if (bus.mem_re && bus.mem_addr == 20'h8) found = 1'b1;
            end
            chk("t3.reach_req8", 32'(found), 32'd1);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0102;
        step();
        redirect_valid = 1'b0;
        chk_out("t3.after_redirect", 1, 32'h8, 0, 32'h0, 0);
        for (int c = 0; c < 10 && bus.mem_re; c++) begin
            chk("t3.addr_hold", 32'(bus.mem_addr), 32'h8);
            step();
        end
        chk_out("t3.drained", 0, 32'h8, 0, 32'h0, 0);
        step();
        chk_out("t3.issue_target", 1, 32'h100, 0, 32'h0, 0);
        for (int c = 0; c < 10 && !bus.instr_valid; c++) step();
        chk("t3.valid", 32'(bus.instr_valid), 32'd1);
        chk("t3.first_pc", bus.instr_pc, 32'h100);
        chk("t3.first_instr", bus.instr, mk(32'h100));

        // Redirect, mem_ready and instr_ready in the same cycle, fill=2.
        $display("redirect + mem_ready + instr_ready same cycle");
        manual = 1'b1;
        man_ready = 1'b0;
        fetch_en = 1'b1;
        bus.instr_ready = 1'b0;
        do_reset();
        step();
        chk_out("t4.issue0", 1, 32'h0, 0, 32'h0, 0);
        man_ready = 1'b1;
        step();
        step();
        chk_out("t4.fill2", 1, 32'h8, 1, 32'h0, 2);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        bus.instr_ready = 1'b1;
        step();
        redirect_valid = 1'b0;
        chk_out("t4.flushed", 0, 32'h8, 0, 32'h0, 0);
        step();
        chk_out("t4.issue_target", 1, 32'h200, 0, 32'h0, 0);
        step();
        chk("t4.valid", 32'(bus.instr_valid), 32'd1);
        chk("t4.pc", bus.instr_pc, 32'h200);
        chk("t4.instr", bus.instr, mk(32'h200));

        // fetch_en dropped while a request is outstanding.
        $display("fetch_en drop mid-request");
        manual = 1'b0;
        man_ready = 1'b0;
        wait_states = 2;
        fetch_en = 1'b1;
        bus.instr_ready = 1'b0;
        do_reset();
        step();
        chk_out("t5.issue0", 1, 32'h0, 0, 32'h0, 0);
        fetch_en = 1'b0;
        for (int c = 0; c < 10 && bus.mem_re; c++) step();
        chk_out("t5.pushed", 0, 32'h0, 1, 32'h0, 1);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("t5.no_issue", 32'(bus.mem_re), 32'd0);
            chk("t5.fill_hold", 32'(fill_level), 32'd1);
        end
        fetch_en = 1'b1;
        step();
        chk_out("t5.resume", 1, 32'h4, 1, 32'h0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
